// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester index.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_WAIT = 2'd3
    } arb_state_t;

    typedef logic req_idx_t;

    localparam int NUM_REQ = 2;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a contested cycle goes to whoever did not win last;
// an uncontested request wins regardless of history.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_idx_t   last_grant,
    output logic       grant_any,
    output req_idx_t   grant_idx
);

    always_comb begin
        grant_any = |valid;
        grant_idx = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end for a single-port memory, registered memory strobes.
// Define MEM_ARB_TIMEOUT_EN to enable the read-response watchdog in ST_WAIT.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | accepting; req_ready pulses for the granted port
// ST_WR   | mem_wr_en high for one cycle
// ST_RD   | mem_rd_en high for one cycle
// ST_WAIT | waiting for mem_valid_out (or watchdog expiry)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  MEM_DEPTH      = 64,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_wr_en,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic [DATA_WIDTH-1:0]   mem_data_out,
    input  logic                    mem_valid_out,
    output logic                    busy
);

    if (TIMEOUT_CYCLES < 1 || MEM_DEPTH < 2) begin : g_param_check
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be >= 1 and MEM_DEPTH >= 2");
    end

    arb_state_t            state, state_nx;
    req_idx_t              last_grant, last_grant_nx;
    req_idx_t              owner, owner_nx;
    logic                  grant_any;
    req_idx_t              grant_idx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  wr_en_nx, rd_en_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic [1:0]            resp_valid_nx;
    logic [DATA_WIDTH-1:0] resp_rdata_nx;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] timer, timer_nx;
    logic             resp_err_nx;
`else
    assign resp_err = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant_any  (grant_any),
        .grant_idx  (grant_idx)
    );

    assign sel_we    = grant_idx ? req_we[1] : req_we[0];
    assign sel_addr  = grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        owner_nx      = owner;
        wr_en_nx      = 1'b0;
        rd_en_nx      = 1'b0;
        addr_nx       = mem_addr;
        wdata_nx      = mem_data_in;
        resp_valid_nx = '0;
        resp_rdata_nx = resp_rdata;
        req_ready     = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        timer_nx      = timer;
        resp_err_nx   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready     = idx_to_onehot(grant_idx);
                    last_grant_nx = grant_idx;
                    owner_nx      = grant_idx;
                    addr_nx       = sel_addr;
                    // mem_data_in only moves on writes so it holds across reads
                    if (sel_we) begin
                        wdata_nx = sel_wdata;
                        wr_en_nx = 1'b1;
                        state_nx = ST_WR;
                    end else begin
                        rd_en_nx = 1'b1;
                        state_nx = ST_RD;
                    end
                end
            end
            ST_WR: state_nx = ST_IDLE;
            ST_RD: begin
                state_nx = ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                timer_nx = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            ST_WAIT: begin
                if (mem_valid_out) begin
                    resp_valid_nx = idx_to_onehot(owner);
                    resp_rdata_nx = mem_data_out;
                    state_nx      = ST_IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timer == '0) begin
                    resp_valid_nx = idx_to_onehot(owner);
                    resp_rdata_nx = '0;
                    resp_err_nx   = 1'b1;
                    state_nx      = ST_IDLE;
                end else begin
                    timer_nx = timer - 1'b1;
                end
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
        // a grant during reset would be discarded, so never advertise one
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            resp_valid  <= '0;
            resp_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            resp_err    <= 1'b0;
            timer       <= '0;
`endif
        end else begin
            state       <= state_nx;
            last_grant  <= last_grant_nx;
            owner       <= owner_nx;
            mem_wr_en   <= wr_en_nx;
            mem_rd_en   <= rd_en_nx;
            mem_addr    <= addr_nx;
            mem_data_in <= wdata_nx;
            resp_valid  <= resp_valid_nx;
            resp_rdata  <= resp_rdata_nx;
`ifdef MEM_ARB_TIMEOUT_EN
            resp_err    <= resp_err_nx;
            timer       <= timer_nx;
`endif
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter DATA_WIDTH, default 32, memory word width in bits.
REQ-002: Parameter MEM_DEPTH, default 64, number of memory words; ADDR_WIDTH = clog2(MEM_DEPTH), localparam.
REQ-003: Parameter TIMEOUT_CYCLES, default 16, read-response watchdog limit in clk cycles.
REQ-004: clk  in  1  sole clock, all logic on rising edge.
REQ-005: rst  in  1  reset, synchronous and active-high.
REQ-006: req_valid  in  2  per-requester command valid (bit i = requester i).
REQ-007: req_ready  out  2  per-requester command accept, one-hot or zero.
REQ-008: req_we  in  2  per-requester command type, 1 = write, 0 = read.
REQ-009: req_addr  in  2*ADDR_WIDTH  packed per-requester address, requester i in slice i.
REQ-010: req_wdata  in  2*DATA_WIDTH  packed per-requester write data.
REQ-011: resp_valid  out  2  per-requester read-data strobe, one-cycle pulse.
REQ-012: resp_rdata  out  DATA_WIDTH  read data, shared, qualified by resp_valid.
REQ-013: resp_err  out  1  read timeout flag, pulses with resp_valid.
REQ-014: mem_wr_en, mem_rd_en  out  1 each  memory strobes.
REQ-015: mem_addr  out  ADDR_WIDTH; mem_data_in  out  DATA_WIDTH  memory command fields.
REQ-016: mem_data_out  in  DATA_WIDTH; mem_valid_out  in  1  memory read return.
REQ-017: busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018: FSM states IDLE, WR, RD, WAIT; all mem_* outputs registered.
REQ-019: IDLE: if any req_valid, grant one requester, assert its req_ready for that cycle, latch we/addr/wdata, go to WR (we=1) or RD (we=0).
REQ-020: Arbitration round-robin: both valid -> grant requester not granted last; single valid -> grant it regardless of history.
REQ-021: WR: mem_wr_en=1, mem_addr/mem_data_in = latched values for exactly one cycle, then IDLE; write costs 2 cycles, no response.
REQ-022: RD: mem_rd_en=1, mem_addr = latched address for exactly one cycle, then WAIT.
REQ-023: WAIT: on mem_valid_out, resp_rdata <= mem_data_out, resp_valid[owner] pulses next cycle, resp_err=0, go to IDLE.
REQ-024: req_ready only asserted in IDLE; requests held while not ready (valid sticky, fields stable).
REQ-025: mem_valid_out outside WAIT is ignored; no response generated.
REQ-026: mem_valid_out in the same cycle as entering WAIT counts as the response.
REQ-027: Outside their active state mem_wr_en, mem_rd_en are 0; mem_addr, mem_data_in hold last values.

Reset
REQ-028: rst high at any clock edge, including mid-WAIT: FSM -> IDLE, req_ready/resp_valid/resp_err/mem_wr_en/mem_rd_en/busy = 0, mem_addr/mem_data_in/resp_rdata = 0, last-grant = 1 (requester 0 wins first contest).
REQ-029: A read outstanding at reset is dropped; a later stray mem_valid_out is ignored per REQ-025.

Configuration
REQ-030: Macro MEM_ARB_TIMEOUT_EN defined: counter in WAIT; after TIMEOUT_CYCLES cycles with no mem_valid_out, resp_valid[owner]=1, resp_rdata=0, resp_err=1, go to IDLE.
REQ-031: Macro undefined: no counter, WAIT holds until mem_valid_out, resp_err tied 0.

Structure
REQ-032: Shared package mem_arb_pkg holds the FSM state enum and requester-index typedef.
REQ-033: One sub-module rr_arb2: 2-way round-robin grant from valid vector and last-grant register.

Verification
REQ-034: Reset, req0 write addr 5 data 0xDEADBEEF -> req_ready[0] cycle 1, mem_wr_en=1 addr 5 data 0xDEADBEEF cycle 2, busy high 1 cycle.
REQ-035: req1 read addr 5, memory returns 0xDEADBEEF 1 cycle after mem_rd_en -> resp_valid=2'b10, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-036: Both valid continuously, 4 writes each -> grants alternate 0,1,0,1,...; first grant to 0 after reset.
REQ-037: rst asserted in WAIT, then mem_valid_out -> no resp_valid, all outputs 0, next request served normally.
REQ-038: With MEM_ARB_TIMEOUT_EN, read with no mem_valid_out -> after 16 cycles resp_valid[owner]=1, resp_rdata 0, resp_err 1; without macro -> busy stays high.
REQ-039: mem_valid_out pulsed in IDLE -> no resp_valid, state unchanged.
